data_mem_loader: RTL and testbench

//  Writer side of the byte-wide data RAM port; the CPU is the reader on that port.

---
 rtl/data_mem_loader.sv | 130 +++++++++++++
 tb/tb_data_mem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_loader.sv
// Frame loader: writes a framed byte stream into data RAM from address 0 and
// holds the CPU in reset until a frame arrives whose checksum matches.
module data_mem_loader #(
    parameter int          ADDR_W = 16,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ld_we,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [7:0]        ld_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    state_t            state, state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       len_q;
    logic [15:0]       len_in;
    logic [ADDR_W:0]   cnt;
    logic [7:0]        sum;
    logic              ready_q;
    logic              xfer;
    logic              last_byte;

    always_comb begin
        xfer      = in_valid & ready_q;
        len_in    = {len_hi, in_data};
        last_byte = (32'(cnt) + 32'd1) == 32'(len_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_data == HDR) begin
                        state_nxt = S_LEN_HI;
                    end
                end
                S_LEN_HI: state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if (len_in == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else if (32'(len_in) > CAP) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_byte) begin
                        state_nxt = S_CSUM;
                    end
                end
                S_CSUM:  state_nxt = (in_data == sum) ? S_DONE : S_ERR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_hold = (state != S_DONE);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        in_ready = ready_q;
    end

    // ready comes up one cycle after reset release and never drops afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            ld_we    <= 1'b0;
            ld_addr  <= '0;
            ld_wdata <= '0;
            len_hi   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            sum      <= '0;
        end else begin
            ready_q <= 1'b1;
            ld_we   <= 1'b0;
            if (xfer) begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (in_data == HDR) begin
                            cnt <= '0;
                            sum <= '0;
                        end
                    end
                    S_LEN_HI: len_hi <= in_data;
                    S_LEN_LO: len_q  <= len_in;
                    S_DATA: begin
                        ld_we    <= 1'b1;
                        ld_addr  <= cnt[ADDR_W-1:0];
                        ld_wdata <= in_data;
                        cnt      <= cnt + (ADDR_W+1)'(1);
                        sum      <= sum + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_loader.sv
// Scoreboard bench for data_mem_loader: expected RAM writes are queued at
// stimulus time and checked by a negedge monitor; status flags checked inline.
module tb_data_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v16, v4;
    logic [7:0]  d16, d4;
    logic        r16, we16, h16, dn16, er16;
    logic [15:0] a16;
    logic [7:0]  w16;
    logic        r4, we4, h4, dn4, er4;
    logic [3:0]  a4;
    logic [7:0]  w4;

    data_mem_loader #(.ADDR_W(16), .HDR(8'hA5)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_data(d16), .in_ready(r16),
        .ld_we(we16), .ld_addr(a16), .ld_wdata(w16),
        .cpu_hold(h16), .done(dn16), .err(er16)
    );

    data_mem_loader #(.ADDR_W(4), .HDR(8'hA5)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
        .ld_we(we4), .ld_addr(a4), .ld_wdata(w4),
        .cpu_hold(h4), .done(dn4), .err(er4)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t q16[$];
    wr_t q4[$];
    wr_t e16, e4;
    int  checks = 0;
    int  errors = 0;
    int  ncyc   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (we16 === 1'b1) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL wr16_extra: got addr %0h data %0h, expected no write", a16, w16);
            end else begin
                e16 = q16.pop_front();
                if (a16 !== e16.addr || w16 !== e16.data || ncyc != e16.cyc) begin
                    errors++;
                    $display("FAIL wr16: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                             a16, w16, ncyc, e16.addr, e16.data, e16.cyc);
                end
            end
        end
        if (we4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL wr4_extra: got addr %0h data %0h, expected no write", a4, w4);
            end else begin
                e4 = q4.pop_front();
                if (a4 !== e4.addr[3:0] || w4 !== e4.data || ncyc != e4.cyc) begin
                    errors++;
                    $display("FAIL wr4: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                             a4, w4, ncyc, e4.addr, e4.data, e4.cyc);
                end
            end
        end
    end

    // One byte per call; a write expected on the following cycle is queued when wr is set.
    task automatic send(input bit sel, input logic [7:0] b, input bit wr, input int addr);
        @(negedge clk);
        #1;
        if (!sel) begin
            v16 = 1'b1;
            d16 = b;
            chk("in_ready16", r16, 1);
            if (wr) q16.push_back('{addr[15:0], b, ncyc + 1});
        end else begin
            v4 = 1'b1;
            d4 = b;
            chk("in_ready4", r4, 1);
            if (wr) q4.push_back('{addr[15:0], b, ncyc + 1});
        end
        @(posedge clk);
        #1;
        v16 = 1'b0;
        v4  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        v16 = 1'b0; d16 = 8'h00;
        v4  = 1'b0; d4  = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hold", h16, 1);
        chk("rst_done", dn16, 0);
        chk("rst_err", er16, 0);
        chk("rst_we", we16, 0);
        chk("rst_ready", r16, 0);
        chk("rst_addr", a16, 0);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", r16, 0);
        @(posedge clk);
        #1;
        chk("ready_after_release16", r16, 1);
        chk("ready_after_release4", r4, 1);

        // good frame
        send(0, 8'hA5, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h03, 0, 0);
        send(0, 8'h10, 1, 0);
        send(0, 8'h20, 1, 1);
        send(0, 8'h30, 1, 2);
        chk("good_hold_pre_csum", h16, 1);
        send(0, 8'h60, 0, 0);
        chk("good_done", dn16, 1);
        chk("good_hold", h16, 0);
        chk("good_err", er16, 0);

        // bad checksum, then empty frame
        send(0, 8'hA5, 0, 0);
        chk("hdr_hold_rise", h16, 1);
        chk("hdr_done_clear", dn16, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h02, 0, 0);
        send(0, 8'hFF, 1, 0);
        send(0, 8'h01, 1, 1);
        send(0, 8'h01, 0, 0);
        chk("bad_err", er16, 1);
        chk("bad_hold", h16, 1);
        chk("bad_done", dn16, 0);
        send(0, 8'hA5, 0, 0);
        chk("hdr_err_clear", er16, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h00, 0, 0);
        chk("len0_done", dn16, 1);
        chk("len0_err", er16, 0);
        chk("len0_hold", h16, 0);

        // noise and gaps
        send(0, 8'h33, 0, 0);
        send(0, 8'h44, 0, 0);
        chk("noise_done", dn16, 1);
        chk("noise_hold", h16, 0);
        send(0, 8'hA5, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h03, 0, 0);
        send(0, 8'h10, 1, 0);
        gap(2);
        send(0, 8'h20, 1, 1);
        gap(3);
        chk("gap_hold", h16, 1);
        chk("gap_done", dn16, 0);
        send(0, 8'h30, 1, 2);
        gap(2);
        chk("gap_csum_wait", dn16, 0);
        send(0, 8'h60, 0, 0);
        chk("gap_done_final", dn16, 1);

        // header value inside payload is data
        send(0, 8'hA5, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h02, 0, 0);
        send(0, 8'hA5, 1, 0);
        send(0, 8'h01, 1, 1);
        send(0, 8'hA6, 0, 0);
        chk("hdr_in_payload_done", dn16, 1);

        // reset mid-DATA
        send(0, 8'hA5, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h05, 0, 0);
        send(0, 8'h11, 1, 0);
        send(0, 8'h22, 1, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_we", we16, 0);
        chk("midrst_hold", h16, 1);
        chk("midrst_done", dn16, 0);
        chk("midrst_err", er16, 0);
        chk("midrst_ready", r16, 0);
        chk("midrst_addr", a16, 0);
        chk("midrst_wdata", w16, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        gap(1);
        send(0, 8'h11, 0, 0);
        send(0, 8'h22, 0, 0);
        send(0, 8'h33, 0, 0);
        chk("postrst_hold", h16, 1);
        chk("postrst_done", dn16, 0);
        send(0, 8'hA5, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'h01, 0, 0);
        send(0, 8'h7E, 1, 0);
        send(0, 8'h7E, 0, 0);
        chk("postrst_frame_done", dn16, 1);

        // small RAM: oversize, then exactly full
        send(1, 8'hA5, 0, 0);
        send(1, 8'h00, 0, 0);
        send(1, 8'h11, 0, 0);
        chk("oversize_err", er4, 1);
        chk("oversize_hold", h4, 1);
        chk("oversize_done", dn4, 0);
        send(1, 8'hA5, 0, 0);
        send(1, 8'h00, 0, 0);
        send(1, 8'h10, 0, 0);
        for (int i = 0; i < 16; i++) begin
            send(1, 8'(i + 1), 1, i);
        end
        chk("full_hold_pre_csum", h4, 1);
        send(1, 8'h88, 0, 0);
        chk("full_done", dn4, 1);
        chk("full_err", er4, 0);
        chk("full_hold", h4, 0);
        chk("full_last_addr", a4, 15);

        gap(3);
        chk("pending16", q16.size(), 0);
        chk("pending4", q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
